// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared types for the data-memory arbiter.
//   state_e   : arbiter FSM state encoding
//   req_id_e  : requester identity (CPU MEM stage or debug/load port)
//   pick_winner(): tie-breaking arbitration between the two requesters
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_e;

  // On a tie the requester that did not get the previous grant wins,
  // so sustained contention alternates between CPU and debug.
  function automatic req_id_e pick_winner(input logic    cpu_req,
                                          input logic    dbg_req,
                                          input req_id_e last_grant);
    req_id_e winner;
    if (cpu_req && dbg_req) begin
      winner = (last_grant == REQ_DBG) ? REQ_CPU : REQ_DBG;
    end else if (dbg_req) begin
      winner = REQ_DBG;
    end else begin
      winner = REQ_CPU;
    end
    return winner;
  endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
//   clk_i   : clock
//   rst_n_i : asynchronous active-low reset, clears the count
//   inc_i   : increment request for this cycle
//   cnt_o   : current count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cnt;

  // Count requested cycles, holding once the maximum is reached.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-ported data memory between the CPU MEM
// stage and a debug/load port, holding each access for MEM_LATENCY cycles.
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   start_i                 : enables new grants (an access in flight finishes)
//   cpu_req/we/addr/wdata_i : CPU request (level, held until served)
//   cpu_rdata_o, cpu_stall_o: CPU load data and pipeline freeze
//   dbg_req/we/addr/wdata_i : debug request (level, held until ack)
//   dbg_rdata_o, dbg_ack_o  : debug read data and one-cycle completion
//   mem_en/we/addr/wdata_o  : memory strobe, write enable, word address, data
//   mem_rdata_i             : memory read data, taken in the last ACCESS cycle
//   stall_cnt_o             : saturating count of CPU stall cycles
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [3:0]        LAT_LAST  = 4'(MEM_LATENCY - 1);
  // Clearing the byte-offset bits at latch time keeps the held address word-aligned.
  localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_e            r_state;
  req_id_e           r_grant;
  req_id_e           r_last_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_lat_cnt;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;

  req_id_e w_winner;
  logic    w_access;
  logic    w_cpu_done;
  logic    w_dbg_done;
  logic    w_cpu_stall;

  // Select the requester that would be granted in an IDLE cycle.
  always_comb begin
    w_winner = pick_winner(cpu_req_i, dbg_req_i, r_last_grant);
  end

  // Arbiter FSM: grant, hold the latched access for MEM_LATENCY cycles, complete.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state      <= IDLE;
      r_grant      <= REQ_CPU;
      r_last_grant <= REQ_DBG;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_lat_cnt    <= 4'd0;
      r_cpu_rdata  <= '0;
      r_dbg_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i && (cpu_req_i || dbg_req_i)) begin
            r_grant      <= w_winner;
            r_last_grant <= w_winner;
            if (w_winner == REQ_DBG) begin
              r_we    <= dbg_we_i;
              r_addr  <= dbg_addr_i & ADDR_MASK;
              r_wdata <= dbg_wdata_i;
            end else begin
              r_we    <= cpu_we_i;
              r_addr  <= cpu_addr_i & ADDR_MASK;
              r_wdata <= cpu_wdata_i;
            end
            r_lat_cnt <= 4'd0;
            r_state   <= ACCESS;
          end
        end
        ACCESS: begin
          r_lat_cnt <= r_lat_cnt + 4'd1;
          if (r_lat_cnt == LAT_LAST) begin
            // A write completion leaves the winner's read data untouched.
            if (!r_we) begin
              if (r_grant == REQ_DBG) begin
                r_dbg_rdata <= mem_rdata_i;
              end else begin
                r_cpu_rdata <= mem_rdata_i;
              end
            end
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign w_access    = (r_state == ACCESS);
  assign w_cpu_done  = (r_state == DONE) && (r_grant == REQ_CPU);
  assign w_dbg_done  = (r_state == DONE) && (r_grant == REQ_DBG);
  // The stall tracks the live request so a CPU blocked by start_i or by the
  // debug port is frozen as well.
  assign w_cpu_stall = cpu_req_i && !w_cpu_done;

  assign mem_en_o    = w_access;
  assign mem_we_o    = w_access && r_we;
  assign mem_addr_o  = w_access ? r_addr  : '0;
  assign mem_wdata_o = w_access ? r_wdata : '0;
  assign cpu_rdata_o = r_cpu_rdata;
  assign dbg_rdata_o = r_dbg_rdata;
  assign dbg_ack_o   = w_dbg_done;
  assign cpu_stall_o = w_cpu_stall;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (w_cpu_stall),
    .cnt_o   (stall_cnt_o)
  );

endmodule
